// File: rtl/soc_fpga_ram_be.sv
// Single-port block RAM with byte-lane writes, 1/2-cycle read latency and a post-reset clear engine.
// Define SOC_FPGA_RAM_PARITY_EN to store and check one even-parity bit per byte lane.
module soc_fpga_ram_be #(
    parameter int DATAWIDTH      = 32,
    parameter int ADDRWIDTH      = 10,
    parameter int BYTEWIDTH      = 8,
    parameter int OUTREG         = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                           PortAClk,
    input  logic                           PortAResetN,
    input  logic                           PortAChipEnable,
    input  logic                           PortAWriteEnable,
    input  logic [DATAWIDTH/BYTEWIDTH-1:0] PortAByteEnable,
    input  logic [ADDRWIDTH-1:0]           PortAAddr,
    input  logic [DATAWIDTH-1:0]           PortADataIn,
    output logic [DATAWIDTH-1:0]           PortADataOut,
    output logic                           PortADataValid,
    output logic                           PortAReady,
    output logic [DATAWIDTH/BYTEWIDTH-1:0] PortAParityErr
);

    localparam int NLANES   = DATAWIDTH / BYTEWIDTH;
    localparam int MEMDEPTH = 2 ** ADDRWIDTH;

    typedef enum logic {CLEAR, RUN} state_e;

    state_e                 state_q;
    logic [ADDRWIDTH-1:0]   clrPtr_q;
    logic                   ready_q;
    logic [DATAWIDTH-1:0]   mem_q [MEMDEPTH];

    logic                   accept;
    logic                   rdEn;
    logic                   memWe;
    logic [NLANES-1:0]      laneWe;
    logic [ADDRWIDTH-1:0]   wAddr;
    logic [DATAWIDTH-1:0]   wData;

    logic [DATAWIDTH-1:0]   rd1_q;
    logic                   vld1_q;
    logic [DATAWIDTH-1:0]   outData;
    logic                   outValid;

`ifdef SOC_FPGA_RAM_PARITY_EN
    logic [NLANES-1:0]      par_q [MEMDEPTH];
    logic [NLANES-1:0]      rdPar1_q;
    logic [NLANES-1:0]      outPar;
`endif

    // The clear engine owns the write port while the FSM is in CLEAR.
    always_comb begin
        accept = PortAChipEnable & ready_q;
        rdEn   = accept & ~PortAWriteEnable;
        if (state_q == CLEAR) begin
            memWe  = PortAResetN;
            laneWe = '1;
            wAddr  = clrPtr_q;
            wData  = '0;
        end else begin
            memWe  = PortAResetN & accept & PortAWriteEnable;
            laneWe = PortAByteEnable;
            wAddr  = PortAAddr;
            wData  = PortADataIn;
        end
    end

    always_ff @(posedge PortAClk) begin
        if (!PortAResetN) begin
            state_q  <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
            clrPtr_q <= '0;
            ready_q  <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    clrPtr_q <= clrPtr_q + ADDRWIDTH'(1);
                    if (&clrPtr_q) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: ready_q <= 1'b1;
            endcase
        end
    end

    always_ff @(posedge PortAClk) begin
        if (memWe) begin
            for (int i = 0; i < NLANES; i++) begin
                if (laneWe[i]) begin
                    mem_q[wAddr][i*BYTEWIDTH +: BYTEWIDTH] <= wData[i*BYTEWIDTH +: BYTEWIDTH];
`ifdef SOC_FPGA_RAM_PARITY_EN
                    par_q[wAddr][i] <= ^wData[i*BYTEWIDTH +: BYTEWIDTH];
`endif
                end
            end
        end
    end

    // First read stage; data only moves on a read so the output holds between reads.
    always_ff @(posedge PortAClk) begin
        if (!PortAResetN) begin
            rd1_q  <= '0;
            vld1_q <= 1'b0;
`ifdef SOC_FPGA_RAM_PARITY_EN
            rdPar1_q <= '0;
`endif
        end else begin
            vld1_q <= rdEn;
            if (rdEn) begin
                rd1_q <= mem_q[PortAAddr];
`ifdef SOC_FPGA_RAM_PARITY_EN
                rdPar1_q <= par_q[PortAAddr];
`endif
            end
        end
    end

    if (OUTREG != 0) begin : gOutReg
        logic [DATAWIDTH-1:0] rd2_q;
        logic                 vld2_q;
`ifdef SOC_FPGA_RAM_PARITY_EN
        logic [NLANES-1:0]    rdPar2_q;
`endif
        always_ff @(posedge PortAClk) begin
            if (!PortAResetN) begin
                rd2_q  <= '0;
                vld2_q <= 1'b0;
`ifdef SOC_FPGA_RAM_PARITY_EN
                rdPar2_q <= '0;
`endif
            end else begin
                vld2_q <= vld1_q;
                if (vld1_q) begin
                    rd2_q <= rd1_q;
`ifdef SOC_FPGA_RAM_PARITY_EN
                    rdPar2_q <= rdPar1_q;
`endif
                end
            end
        end
        assign outData  = rd2_q;
        assign outValid = vld2_q;
`ifdef SOC_FPGA_RAM_PARITY_EN
        assign outPar   = rdPar2_q;
`endif
    end else begin : gNoOutReg
        assign outData  = rd1_q;
        assign outValid = vld1_q;
`ifdef SOC_FPGA_RAM_PARITY_EN
        assign outPar   = rdPar1_q;
`endif
    end

    assign PortADataOut   = outData;
    assign PortADataValid = outValid;
    assign PortAReady     = ready_q;

`ifdef SOC_FPGA_RAM_PARITY_EN
    always_comb begin
        PortAParityErr = '0;
        if (outValid) begin
            for (int i = 0; i < NLANES; i++) begin
                PortAParityErr[i] = (^outData[i*BYTEWIDTH +: BYTEWIDTH]) ^ outPar[i];
            end
        end
    end
`else
    assign PortAParityErr = '0;
`endif

endmodule

// File: tb/tb_soc_fpga_ram_be.sv
// Self-checking bench for soc_fpga_ram_be: two latencies plus a no-clear instance, checked every cycle
// against an array/queue model of the memory.
module tb_soc_fpga_ram_be;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int BW    = 8;
    localparam int NL    = DW / BW;
    localparam int DEPTH = 2 ** AW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstN, ce, we;
    logic [NL-1:0] be;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;

    logic [DW-1:0] d0Data, d1Data, d2Data;
    logic          d0Valid, d1Valid, d2Valid;
    logic          d0Ready, d1Ready, d2Ready;
    logic [NL-1:0] d0Err, d1Err, d2Err;

    soc_fpga_ram_be #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .BYTEWIDTH(BW), .OUTREG(0), .CLEAR_ON_RESET(1)) dut0 (
        .PortAClk(clk), .PortAResetN(rstN), .PortAChipEnable(ce), .PortAWriteEnable(we),
        .PortAByteEnable(be), .PortAAddr(addr), .PortADataIn(din), .PortADataOut(d0Data),
        .PortADataValid(d0Valid), .PortAReady(d0Ready), .PortAParityErr(d0Err));

    soc_fpga_ram_be #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .BYTEWIDTH(BW), .OUTREG(1), .CLEAR_ON_RESET(1)) dut1 (
        .PortAClk(clk), .PortAResetN(rstN), .PortAChipEnable(ce), .PortAWriteEnable(we),
        .PortAByteEnable(be), .PortAAddr(addr), .PortADataIn(din), .PortADataOut(d1Data),
        .PortADataValid(d1Valid), .PortAReady(d1Ready), .PortAParityErr(d1Err));

    soc_fpga_ram_be #(.DATAWIDTH(DW), .ADDRWIDTH(AW), .BYTEWIDTH(BW), .OUTREG(0), .CLEAR_ON_RESET(0)) dut2 (
        .PortAClk(clk), .PortAResetN(rstN), .PortAChipEnable(ce), .PortAWriteEnable(we),
        .PortAByteEnable(be), .PortAAddr(addr), .PortADataIn(din), .PortADataOut(d2Data),
        .PortADataValid(d2Valid), .PortAReady(d2Ready), .PortAParityErr(d2Err));

    typedef struct {
        int            due;
        logic [DW-1:0] data;
        logic [NL-1:0] err;
    } rdEntry_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int clearLeft = DEPTH;
    int pulses0 = 0;
    int pulses1 = 0;

    logic [DW-1:0] mMem [DEPTH];
    logic [NL-1:0] mCorrupt [DEPTH];
    rdEntry_t      q0[$];
    rdEntry_t      q1[$];
    logic [DW-1:0] expOut0 = '0, expOut1 = '0;
    logic          expV0 = 1'b0, expV1 = 1'b0, expV2 = 1'b0;
    logic [NL-1:0] expE0 = '0, expE1 = '0;
    logic          expReady = 1'b0, expReady2 = 1'b0;

    task automatic compare(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    // Effect of one rising edge on the model, using the inputs currently applied.
    task automatic modelEdge();
        logic     acc;
        rdEntry_t r;
        cyc++;
        expV0 = 1'b0;
        expV1 = 1'b0;
        expE0 = '0;
        expE1 = '0;
        if (!rstN) begin
            clearLeft = DEPTH;
            expReady  = 1'b0;
            expReady2 = 1'b0;
            expV2     = 1'b0;
            q0.delete();
            q1.delete();
            expOut0 = '0;
            expOut1 = '0;
        end else begin
            acc   = ce && expReady;
            expV2 = ce && !we && expReady2;
            if (clearLeft > 0) begin
                mMem[DEPTH-clearLeft]     = '0;
                mCorrupt[DEPTH-clearLeft] = '0;
                clearLeft--;
            end else if (acc && we) begin
                for (int i = 0; i < NL; i++) begin
                    if (be[i]) begin
                        mMem[addr][i*BW +: BW] = din[i*BW +: BW];
                        mCorrupt[addr][i]      = 1'b0;
                    end
                end
            end else if (acc) begin
                q0.push_back('{cyc, mMem[addr], mCorrupt[addr]});
                q1.push_back('{cyc + 1, mMem[addr], mCorrupt[addr]});
            end
            expReady  = (clearLeft == 0);
            expReady2 = 1'b1;
            if (q0.size() > 0 && q0[0].due == cyc) begin
                r = q0.pop_front();
                expOut0 = r.data; expV0 = 1'b1; expE0 = r.err;
            end
            if (q1.size() > 0 && q1[0].due == cyc) begin
                r = q1.pop_front();
                expOut1 = r.data; expV1 = 1'b1; expE1 = r.err;
            end
        end
    endtask

    task automatic checkOutput();
        if (d0Valid === 1'b1) pulses0++;
        if (d1Valid === 1'b1) pulses1++;
        compare("ready0", DW'(d0Ready), DW'(expReady));
        compare("ready1", DW'(d1Ready), DW'(expReady));
        compare("ready2", DW'(d2Ready), DW'(expReady2));
        compare("valid0", DW'(d0Valid), DW'(expV0));
        compare("valid1", DW'(d1Valid), DW'(expV1));
        compare("valid2", DW'(d2Valid), DW'(expV2));
        compare("data0", d0Data, expOut0);
        compare("data1", d1Data, expOut1);
        compare("perr0", DW'(d0Err), DW'(expE0));
        compare("perr1", DW'(d1Err), DW'(expE1));
    endtask

    // Called just after a falling edge; returns at the next falling edge with outputs checked.
    task automatic applyStimulus(input logic r, input logic c, input logic w, input logic [NL-1:0] b,
                                 input logic [AW-1:0] a, input logic [DW-1:0] d);
        rstN = r; ce = c; we = w; be = b; addr = a; din = d;
        @(posedge clk);
        modelEdge();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic junkStep(input logic r);
        applyStimulus(r, 1'($urandom), 1'($urandom), NL'($urandom), AW'($urandom), $urandom);
    endtask

    task automatic waitReady(output int n);
        n = 0;
        while (d0Ready !== 1'b1 && n < 40) begin
            junkStep(1'b1);
            n++;
        end
    endtask

    int n;
    int p0, p1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rstN = 1'b0; ce = 1'b0; we = 1'b0; be = '0; addr = '0; din = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mMem[i] = 'x;
            mCorrupt[i] = '0;
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) junkStep(1'b0);
        compare("rstReady", DW'(d0Ready), 0);
        compare("rstData", d0Data, 0);

        waitReady(n);
        compare("clearLen", n, DEPTH);
        compare("noClrReady", DW'(d2Ready), 1);

        p0 = pulses0; p1 = pulses1;
        for (int a = 0; a < DEPTH; a++) applyStimulus(1, 1, 0, '0, AW'(a), '0);
        applyStimulus(1, 0, 0, '0, '0, '0);
        applyStimulus(1, 0, 0, '0, '0, '0);
        compare("pulses0", pulses0 - p0, DEPTH);
        compare("pulses1", pulses1 - p1, DEPTH);

        applyStimulus(1, 1, 1, 4'b1111, 4'd3, 32'hDEADBEEF);
        applyStimulus(1, 1, 1, 4'b0101, 4'd3, 32'h11223344);
        compare("modelMerge", mMem[3], 32'hDE22BE44);
        applyStimulus(1, 1, 0, '0, 4'd3, '0);
        compare("lat0Valid", DW'(d0Valid), 1);
        compare("lat0Data", d0Data, 32'hDE22BE44);
        compare("lat1Early", DW'(d1Valid), 0);
        applyStimulus(1, 0, 0, '0, '0, '0);
        compare("lat1Valid", DW'(d1Valid), 1);
        compare("lat1Data", d1Data, 32'hDE22BE44);

        for (int a = 0; a < 4; a++) applyStimulus(1, 1, 0, '0, AW'(a), '0);
        applyStimulus(1, 0, 0, '0, '0, '0);

        applyStimulus(1, 1, 0, '0, 4'd3, '0);
        applyStimulus(1, 0, 1, 4'b1111, 4'd5, 32'hCAFEF00D);
        applyStimulus(1, 1, 1, 4'b0000, 4'd5, 32'hCAFEF00D);
        compare("holdData", d0Data, 32'hDE22BE44);
        compare("holdNoValid", DW'(d0Valid), 0);
        applyStimulus(1, 1, 0, '0, 4'd5, '0);
        compare("addr5Kept", d0Data, 0);
        applyStimulus(1, 0, 0, '0, '0, '0);

        junkStep(1'b0);
        for (int i = 0; i < 7; i++) junkStep(1'b1);
        junkStep(1'b0);
        waitReady(n);
        compare("reclearLen", n, DEPTH);
        for (int a = 0; a < DEPTH; a++) applyStimulus(1, 1, 0, '0, AW'(a), '0);
        applyStimulus(1, 0, 0, '0, '0, '0);

`ifdef SOC_FPGA_RAM_PARITY_EN
        dut0.mem_q[2] = dut0.mem_q[2] ^ 32'h0000_0200;
        dut1.mem_q[2] = dut1.mem_q[2] ^ 32'h0000_0200;
        mMem[2]     = mMem[2] ^ 32'h0000_0200;
        mCorrupt[2] = mCorrupt[2] ^ 4'b0010;
        applyStimulus(1, 1, 0, '0, 4'd2, '0);
        compare("parFlip0", DW'(d0Err), 32'h2);
        applyStimulus(1, 1, 0, '0, 4'd1, '0);
        compare("parFlip1", DW'(d1Err), 32'h2);
        compare("parClean0", DW'(d0Err), 0);
        applyStimulus(1, 0, 0, '0, '0, '0);
`endif

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                junkStep(1'b0);
            end else begin
                applyStimulus(1, ($urandom_range(0, 3) != 0), 1'($urandom), NL'($urandom),
                              AW'($urandom), $urandom);
            end
        end
        applyStimulus(1, 0, 0, '0, '0, '0);
        applyStimulus(1, 0, 0, '0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
